// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller for a minimal ADD/LW/SW core.
// Sequences fetch, decode, execute, memory and write-back, and counts retirements.
module multicycle_controller #(
    parameter int                    OPCODE_W = 6,
    parameter int                    ALU_W    = 3,
    parameter logic [OPCODE_W-1:0]   OP_ADD   = 6'b000001,
    parameter logic [OPCODE_W-1:0]   OP_LW    = 6'b000010,
    parameter logic [OPCODE_W-1:0]   OP_SW    = 6'b000100,
    parameter logic [ALU_W-1:0]      ALU_ADD  = 3'b101,
    parameter int                    CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                Pc_Write,
    output logic                Ir_Write,
    output logic                I_Read,
    output logic                Reg_Dst,
    output logic                Reg_Write,
    output logic                Alu_Src,
    output logic                Mem_Write,
    output logic                Mem_Read,
    output logic                Mem_To_Reg,
    output logic [ALU_W-1:0]    Alu_Control,
    output logic                Instr_Done,
    output logic                Illegal,
    output logic                Err_Sticky,
    output logic [CNT_W-1:0]    Retired_Count,
    output logic [2:0]          State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                err_sticky_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire;
    logic                op_valid;
    logic                is_add;
    logic                is_lw;

    assign op_valid = (opcode == OP_ADD) || (opcode == OP_LW) || (opcode == OP_SW);
    assign is_add   = (op_q == OP_ADD);
    assign is_lw    = (op_q == OP_LW);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = op_valid ? S_EXEC : S_ERR;
            end
            S_EXEC: begin
                state_d = is_add ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = en ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = en ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
                state_d = en ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                if (!op_valid) err_sticky_q <= 1'b1;
            end
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Controls are gated by rst so a reset mid-access drops strobes at once.
    always_comb begin
        Pc_Write    = 1'b0;
        Ir_Write    = 1'b0;
        I_Read      = 1'b0;
        Reg_Dst     = 1'b0;
        Reg_Write   = 1'b0;
        Alu_Src     = 1'b0;
        Mem_Write   = 1'b0;
        Mem_Read    = 1'b0;
        Mem_To_Reg  = 1'b0;
        Alu_Control = '0;
        Illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    I_Read = 1'b1;
                    if (mem_ready) begin
                        Ir_Write = 1'b1;
                        Pc_Write = 1'b1;
                    end
                end
                S_EXEC: begin
                    Alu_Control = ALU_ADD;
                    Alu_Src     = !is_add;
                end
                S_MEM: begin
                    Alu_Control = ALU_ADD;
                    Alu_Src     = 1'b1;
                    Mem_Read    = is_lw;
                    Mem_Write   = !is_lw;
                end
                S_WB: begin
                    Reg_Write  = 1'b1;
                    Reg_Dst    = is_add;
                    Mem_To_Reg = is_add;
                end
                S_ERR: begin
                    Illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Instr_Done    = retire && !rst;
    assign Err_Sticky    = err_sticky_q;
    assign Retired_Count = cnt_q;
    assign State         = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode width.
REQ-002 SHALL have parameter ALU_W, default 3, ALU control width.
REQ-003 SHALL have parameters OP_ADD/OP_LW/OP_SW, defaults 6'b000001/6'b000010/6'b000100, opcode encodings.
REQ-004 SHALL have parameter ALU_ADD, default 3'b101, ALU code driven in EXEC/MEM.
REQ-005 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-006 SHALL use one clock and a synchronous active-high reset: ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-007 Ports: en  in  1  run enable; opcode  in  OPCODE_W  from instruction register; mem_ready  in  1  memory access complete this cycle.
REQ-008 Ports: Pc_Write, Ir_Write, I_Read  out  1  PC update, IR load, instruction fetch request.
REQ-009 Ports: Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg  out  1  datapath controls; Alu_Control  out  ALU_W.
REQ-010 Ports: Instr_Done  out  1  retire pulse; Illegal  out  1  illegal-opcode pulse; Err_Sticky  out  1; Retired_Count  out  CNT_W; State  out  3.

Function
REQ-011 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6; State outputs current encoding.
REQ-012 All control outputs SHALL be 0 in any state/condition not listed below.
REQ-013 IDLE: next FETCH when en=1, else stay.
REQ-014 FETCH: I_Read=1; while mem_ready=0 stay; when mem_ready=1, Ir_Write=1 and Pc_Write=1 same cycle, next DECODE.
REQ-015 DECODE: latch opcode into internal op_q; next EXEC if opcode is OP_ADD/OP_LW/OP_SW, else ERR.
REQ-016 EXEC: Alu_Control=ALU_ADD; Alu_Src=0 for ADD, 1 for LW/SW; next WB for ADD, MEM for LW/SW.
REQ-017 MEM: Alu_Src=1, Alu_Control=ALU_ADD; Mem_Read=1 (LW) or Mem_Write=1 (SW) held until mem_ready=1; on mem_ready LW->WB, SW->retire.
REQ-018 WB: Reg_Write=1; ADD: Reg_Dst=1, Mem_To_Reg=1; LW: Reg_Dst=0, Mem_To_Reg=0; then retire.
REQ-019 Retire (WB exit, or SW MEM exit with mem_ready): Instr_Done=1 for that cycle, Retired_Count increments by 1 modulo 2^CNT_W (wraps to 0 from all-ones); next FETCH if en=1, else IDLE.
REQ-020 ERR: Illegal=1 one cycle, Err_Sticky set to 1 and held until reset; no register/memory write; next FETCH if en=1, else IDLE; Retired_Count unchanged.
REQ-021 en SHALL only be sampled in IDLE and at retire/ERR exit; deasserting en mid-instruction SHALL let the instruction complete.
REQ-022 Zero-wait-state latency (mem_ready=1 always): ADD 4 cycles, LW 5, SW 4, illegal 3, FETCH entry to next FETCH entry.
REQ-023 op_q SHALL hold constant from DECODE until retire/ERR; opcode changes after DECODE SHALL have no effect.

Reset
REQ-024 rst=1 at a rising edge SHALL force State=IDLE, op_q=0, Err_Sticky=0, Retired_Count=0, regardless of current state or mem_ready.
REQ-025 During and the cycle after reset, all control outputs, Instr_Done and Illegal SHALL be 0; reset mid-MEM SHALL drop Mem_Write/Mem_Read the next cycle.

Verification
REQ-026 rst, en=1, mem_ready=1, opcode=000001 -> States 1,2,3,5, WB shows Reg_Write=1 Reg_Dst=1 Mem_To_Reg=1, Instr_Done pulse, Retired_Count=1.
REQ-027 opcode=000010, mem_ready low 3 cycles in MEM -> Mem_Read=1 for 4 cycles, then WB Reg_Write=1 Mem_To_Reg=0, Retired_Count+1.
REQ-028 opcode=000100 -> MEM Mem_Write=1 Alu_Src=1 Alu_Control=101, retire from MEM, Reg_Write never 1.
REQ-029 opcode=111111 -> DECODE->ERR, Illegal pulse 1 cycle, Err_Sticky=1 persists over later ADDs, count unchanged.
REQ-030 CNT_W=4, 16 back-to-back ADDs -> Retired_Count wraps 15->0; en dropped in EXEC -> instruction retires, then IDLE.
REQ-031 rst asserted in MEM during SW -> next cycle State=0, Mem_Write=0, Retired_Count=0, Err_Sticky=0.
